baggage_drop_seq: RTL

Sequential, parametrised successor of the baggage-drop decision path. On a `start` request it captures N height sensors, forms their truncated mean (optionally excluding faulty zero readings), computes a fixed-point square root iteratively, derives the fall time `t_act`, compares it to `t_lim`, and drives the drop command and four seven-segment digits. It sits between the sensor interface and the drop actuator/display, replacing the purely combinational path with a start/busy/done handshake.

---
 rtl/baggage_drop_seq_pkg.sv | 37 +++
 rtl/baggage_drop_seq_if.sv | 32 +++
 rtl/baggage_drop_seq_sqrt.sv | 96 +++++++++
 rtl/baggage_drop_seq.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/baggage_drop_seq_pkg.sv
// Shared types and constants for the sequential baggage-drop decision path:
// FSM state encoding, seven-segment glyphs and the display-word helper.
package baggage_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_DIV     = 3'd2,
    ST_SQRT    = 3'd3,
    ST_DECIDE  = 3'd4
  } state_e;

  localparam int FRAC_W = 8;

  // Glyphs in gfedcba order, 1 = segment lit
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_R     = 7'h50;
  localparam logic [6:0] SEG_O     = 7'h3F;
  localparam logic [6:0] SEG_P     = 7'h73;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Four digits packed leftmost first: {seg1, seg2, seg3, seg4}
  function automatic logic [27:0] display_word(input logic drop, input logic fault);
    logic [27:0] word;
    if (fault) begin
      word = {SEG_E, SEG_R, SEG_R, SEG_BLANK};
    end else if (drop) begin
      word = {SEG_D, SEG_R, SEG_O, SEG_P};
    end else begin
      word = {SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH};
    end
    return word;
  endfunction

endpackage

// File: rtl/baggage_drop_seq_if.sv
// Request/result bundle between the sensor front end and baggage_drop_seq.
interface baggage_drop_seq_if #(
  parameter int N_SENSORS = 4,
  parameter int SENSOR_W  = 8,
  parameter int T_W       = 16
);
  logic                          start;
  logic [N_SENSORS*SENSOR_W-1:0] sensors;
  logic [T_W-1:0]                t_lim;
  logic                          drop_en;
  logic                          busy;
  logic                          done;
  logic [T_W-1:0]                t_act;
  logic                          drop_activated;
  logic                          sensor_fault;
  logic [6:0]                    seven_seg1;
  logic [6:0]                    seven_seg2;
  logic [6:0]                    seven_seg3;
  logic [6:0]                    seven_seg4;

  modport master (
    output start, sensors, t_lim, drop_en,
    input  busy, done, t_act, drop_activated, sensor_fault,
    input  seven_seg1, seven_seg2, seven_seg3, seven_seg4
  );

  modport slave (
    input  start, sensors, t_lim, drop_en,
    output busy, done, t_act, drop_activated, sensor_fault,
    output seven_seg1, seven_seg2, seven_seg3, seven_seg4
  );
endinterface

// File: rtl/baggage_drop_seq_sqrt.sv
// seq_sqrt: iterative restoring square root, one root bit per cycle.
// The first iteration runs in the start cycle so the result is ready IN_W/2 cycles later.
module seq_sqrt #(
  parameter int IN_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [IN_W-1:0]   radicand,
  output logic [IN_W/2-1:0] root,
  output logic              done
);

  localparam int ROOT_W = IN_W / 2;
  localparam int REM_W  = ROOT_W + 3;
  localparam int CNT_W  = $clog2(ROOT_W + 1);

  logic              busy_r;
  logic              done_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [REM_W-1:0]  rem_r;
  logic [ROOT_W-1:0] root_r;
  logic [IN_W-1:0]   rad_r;

  logic              start_ok_s;
  logic [REM_W-1:0]  rem_in_s;
  logic [ROOT_W-1:0] root_in_s;
  logic [IN_W-1:0]   rad_in_s;
  logic [REM_W-1:0]  shifted_s;
  logic [REM_W-1:0]  trial_s;
  logic [REM_W-1:0]  rem_nxt_s;
  logic [ROOT_W-1:0] root_nxt_s;
  logic [IN_W-1:0]   rad_nxt_s;

  // One restoring step, fed from the inputs on the start cycle
  always_comb begin
    start_ok_s = start & ~busy_r;
    if (start_ok_s) begin
      rem_in_s  = {REM_W{1'b0}};
      root_in_s = {ROOT_W{1'b0}};
      rad_in_s  = radicand;
    end else begin
      rem_in_s  = rem_r;
      root_in_s = root_r;
      rad_in_s  = rad_r;
    end
    shifted_s = {rem_in_s[REM_W-3:0], rad_in_s[IN_W-1 -: 2]};
    trial_s   = {1'b0, root_in_s, 2'b01};
    rad_nxt_s = {rad_in_s[IN_W-3:0], 2'b00};
    if (shifted_s >= trial_s) begin
      rem_nxt_s  = shifted_s - trial_s;
      root_nxt_s = {root_in_s[ROOT_W-2:0], 1'b1};
    end else begin
      rem_nxt_s  = shifted_s;
      root_nxt_s = {root_in_s[ROOT_W-2:0], 1'b0};
    end
  end

  // Iteration counter and working registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      cnt_r  <= {CNT_W{1'b0}};
      rem_r  <= {REM_W{1'b0}};
      root_r <= {ROOT_W{1'b0}};
      rad_r  <= {IN_W{1'b0}};
    end else begin
      done_r <= 1'b0;
      if (start_ok_s) begin
        busy_r <= 1'b1;
        cnt_r  <= {{(CNT_W-1){1'b0}}, 1'b1};
        rem_r  <= rem_nxt_s;
        root_r <= root_nxt_s;
        rad_r  <= rad_nxt_s;
      end else if (busy_r) begin
        rem_r  <= rem_nxt_s;
        root_r <= root_nxt_s;
        rad_r  <= rad_nxt_s;
        if (cnt_r == CNT_W'(ROOT_W - 1)) begin
          busy_r <= 1'b0;
          cnt_r  <= {CNT_W{1'b0}};
          done_r <= 1'b1;
        end else begin
          cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end else begin
        busy_r <= 1'b0;
      end
    end
  end

  assign root = root_r;
  assign done = done_r;

endmodule

// File: rtl/baggage_drop_seq.sv
// baggage_drop_seq: start/busy/done sequencer computing mean height, fall time and drop decision.
// Optional build macro BAGGAGE_SENSOR_MASK_EN excludes zero readings and enables the fault path.
module baggage_drop_seq
  import baggage_pkg::*;
#(
  parameter int N_SENSORS = 4,
  parameter int SENSOR_W  = 8,
  parameter int T_W       = 16
) (
  input logic               clk,
  input logic               rst_n,
  baggage_drop_seq_if.slave bus
);

  localparam int ROOT_W = SENSOR_W / 2 + FRAC_W;
  localparam int SUM_W  = SENSOR_W + $clog2(N_SENSORS);
  localparam int REM_W  = SUM_W - SENSOR_W + 1;
  localparam int VCNT_W = $clog2(N_SENSORS + 1);
  localparam int RAD_W  = SENSOR_W + 2 * FRAC_W;
  localparam int CNT_W  = 5;

  state_e              state_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [SUM_W-1:0]    sum_r;
  logic [VCNT_W-1:0]   vcnt_r;
  logic [REM_W-1:0]    rem_r;
  logic [SENSOR_W-1:0] q_r;
  logic [T_W-1:0]      t_lim_r;
  logic                busy_r;
  logic                done_r;
  logic [T_W-1:0]      t_act_r;
  logic                drop_r;
  logic                fault_r;
  logic [27:0]         seg_r;

  logic [SENSOR_W-1:0] reading_s;
  logic                valid_s;
  logic                fault_s;
  logic [SUM_W-1:0]    sum_nxt_s;
  logic [VCNT_W-1:0]   vcnt_nxt_s;
  logic [REM_W-1:0]    trial_s;
  logic                div_ge_s;
  logic [REM_W-1:0]    rem_nxt_s;
  logic [T_W-1:0]      t_act_nxt_s;
  logic                drop_nxt_s;
  logic                sqrt_start_s;
  logic [ROOT_W-1:0]   root_s;
  logic                sqrt_done_s;

  // Capture accumulation, one division step and the decision terms
  always_comb begin
    reading_s = bus.sensors[int'(cnt_r)*SENSOR_W +: SENSOR_W];
`ifdef BAGGAGE_SENSOR_MASK_EN
    valid_s = (reading_s != {SENSOR_W{1'b0}});
    fault_s = (vcnt_r == {VCNT_W{1'b0}});
`else
    valid_s = 1'b1;
    fault_s = 1'b0;
`endif
    if (valid_s) begin
      sum_nxt_s  = sum_r + SUM_W'(reading_s);
      vcnt_nxt_s = vcnt_r + {{(VCNT_W-1){1'b0}}, 1'b1};
    end else begin
      sum_nxt_s  = sum_r;
      vcnt_nxt_s = vcnt_r;
    end
    trial_s  = {rem_r[REM_W-2:0], q_r[SENSOR_W-1]};
    div_ge_s = (trial_s >= REM_W'(vcnt_r));
    if (div_ge_s) begin
      rem_nxt_s = trial_s - REM_W'(vcnt_r);
    end else begin
      rem_nxt_s = trial_s;
    end
    // Fault path never starts the root, so t_act falls back to zero there
    if (sqrt_done_s) begin
      t_act_nxt_s = T_W'(root_s[ROOT_W-1:1]);
    end else begin
      t_act_nxt_s = {T_W{1'b0}};
    end
    drop_nxt_s   = bus.drop_en & ~fault_s & (t_act_nxt_s <= t_lim_r);
    sqrt_start_s = (state_r == ST_SQRT) && (cnt_r == {CNT_W{1'b0}});
  end

  seq_sqrt #(.IN_W(RAD_W)) u_sqrt (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (sqrt_start_s),
    .radicand ({q_r, {(2*FRAC_W){1'b0}}}),
    .root     (root_s),
    .done     (sqrt_done_s)
  );

  // Sequencer FSM with registered handshake and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      sum_r   <= {SUM_W{1'b0}};
      vcnt_r  <= {VCNT_W{1'b0}};
      rem_r   <= {REM_W{1'b0}};
      q_r     <= {SENSOR_W{1'b0}};
      t_lim_r <= {T_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      t_act_r <= {T_W{1'b0}};
      drop_r  <= 1'b0;
      fault_r <= 1'b0;
      seg_r   <= 28'h0000000;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // A start coinciding with done is dropped so each run needs a fresh request
          if (bus.start && !done_r) begin
            state_r <= ST_CAPTURE;
            busy_r  <= 1'b1;
            cnt_r   <= {CNT_W{1'b0}};
            sum_r   <= {SUM_W{1'b0}};
            vcnt_r  <= {VCNT_W{1'b0}};
            t_lim_r <= bus.t_lim;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_CAPTURE: begin
          sum_r  <= sum_nxt_s;
          vcnt_r <= vcnt_nxt_s;
          if (cnt_r == CNT_W'(N_SENSORS - 1)) begin
            cnt_r   <= {CNT_W{1'b0}};
            rem_r   <= REM_W'(sum_nxt_s >> SENSOR_W);
            q_r     <= sum_nxt_s[SENSOR_W-1:0];
            state_r <= ST_DIV;
          end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_DIV: begin
          rem_r <= rem_nxt_s;
          q_r   <= {q_r[SENSOR_W-2:0], div_ge_s};
          if (cnt_r == CNT_W'(SENSOR_W - 1)) begin
            cnt_r <= {CNT_W{1'b0}};
            if (fault_s) begin
              state_r <= ST_DECIDE;
            end else begin
              state_r <= ST_SQRT;
            end
          end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_SQRT: begin
          if (cnt_r == CNT_W'(ROOT_W - 1)) begin
            cnt_r   <= {CNT_W{1'b0}};
            state_r <= ST_DECIDE;
          end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_DECIDE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
          t_act_r <= t_act_nxt_s;
          drop_r  <= drop_nxt_s;
          fault_r <= fault_s;
          seg_r   <= display_word(drop_nxt_s, fault_s);
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          cnt_r   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign bus.busy           = busy_r;
  assign bus.done           = done_r;
  assign bus.t_act          = t_act_r;
  assign bus.drop_activated = drop_r;
  assign bus.sensor_fault   = fault_r;
  assign bus.seven_seg1     = seg_r[27:21];
  assign bus.seven_seg2     = seg_r[20:14];
  assign bus.seven_seg3     = seg_r[13:7];
  assign bus.seven_seg4     = seg_r[6:0];

endmodule
